// File: rtl/spi_pkg.sv
// Shared types and default sizing for the SPI arbiter.
package spi_pkg;

  localparam int DEF_DATA_LENGTH    = 8;
  localparam int DEF_NUM_REQ        = 4;
  localparam int DEF_LAUNCH_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2,
    RESP      = 2'd3
  } arb_state_t;

endpackage

// File: rtl/spi_rr_arb.sv
// Combinational round-robin search: first requester above last_grant, wrapping.
module spi_rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_grant,
  output logic               found,
  output logic [IW-1:0]      index
);

  int cand;

  // Walk from the farthest candidate toward the nearest so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    index = '0;
    cand  = 0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      cand = (int'(last_grant) + off) % NUM_REQ;
      if (req[IW'(cand)]) begin
        found = 1'b1;
        index = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one external SPI master among NUM_REQ requesters, one transfer at a time,
// with round-robin grants, a launch timeout and per-slave chip-select routing.
module spi_arbiter
  import spi_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int DATA_LENGTH    = DEF_DATA_LENGTH,
  parameter int LAUNCH_TIMEOUT = DEF_LAUNCH_TIMEOUT
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_LENGTH-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_LENGTH-1:0]         rsp_data,
  output logic                           rsp_err,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id,
  output logic                           m_start,
  output logic [DATA_LENGTH-1:0]         m_data_in,
  input  logic [DATA_LENGTH-1:0]         m_data_out,
  input  logic                           m_busy,
  input  logic                           m_done,
  input  logic                           m_cs_n,
  output logic [NUM_REQ-1:0]             spi_cs_n
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(LAUNCH_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(LAUNCH_TIMEOUT - 1);

  arb_state_t             state_q, state_d;
  logic [IW-1:0]          grant_q, grant_d;
  logic [IW-1:0]          last_q, last_d;
  logic [DATA_LENGTH-1:0] tx_q, tx_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [DATA_LENGTH-1:0] rsp_data_q, rsp_data_d;
  logic                   rsp_err_q, rsp_err_d;

  logic                   rr_found;
  logic [IW-1:0]          rr_idx;
  logic [DATA_LENGTH-1:0] req_words [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign req_words[i] = req_data[i*DATA_LENGTH +: DATA_LENGTH];
  end

  spi_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_rr_arb (
    .req        (req_valid),
    .last_grant (last_q),
    .found      (rr_found),
    .index      (rr_idx)
  );

  // NOTE: state updates use non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_q     <= IW'(NUM_REQ - 1);
      tx_q       <= '0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      tx_q       <= tx_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    tx_d       = tx_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    req_ready  = '0;
    rsp_valid  = '0;
    m_start    = 1'b0;
    spi_cs_n   = '1;

    unique case (state_q)
      IDLE: begin
        if (rr_found) begin
          req_ready[rr_idx] = 1'b1;
          grant_d           = rr_idx;
          tx_d              = req_words[rr_idx];
          cnt_d             = '0;
          state_d           = LAUNCH;
        end
      end

      LAUNCH: begin
        m_start           = 1'b1;
        spi_cs_n[grant_q] = m_cs_n;
        if (m_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_LAST) begin
          // Master never acknowledged: report an error with a zeroed RX word.
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      WAIT_DONE: begin
        spi_cs_n[grant_q] = m_cs_n;
        if (m_done) begin
          rsp_data_d = m_data_out;
          rsp_err_d  = 1'b0;
          state_d    = RESP;
        end
      end

      RESP: begin
        spi_cs_n[grant_q]  = m_cs_n;
        rsp_valid[grant_q] = 1'b1;
        last_d             = grant_q;
        state_d            = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign grant_id  = grant_q;
  assign m_data_in = tx_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed bench for spi_arbiter: vector table of transfers plus hand-written
// timeout, stray-done and reset-abort sequences.
module tb_spi_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_err;
  logic [1:0]  grant_id;
  logic        m_start;
  logic [7:0]  m_data_in;
  logic [7:0]  m_data_out;
  logic        m_busy;
  logic        m_done;
  logic        m_cs_n;
  logic [3:0]  spi_cs_n;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] prev_rx;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [7:0]  rx;
    logic [1:0]  exp_g;
    logic [7:0]  exp_tx;
  } vec_t;

  vec_t vecs [11];

  always #5 clk = ~clk;

  spi_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .grant_id   (grant_id),
    .m_start    (m_start),
    .m_data_in  (m_data_in),
    .m_data_out (m_data_out),
    .m_busy     (m_busy),
    .m_done     (m_done),
    .m_cs_n     (m_cs_n),
    .spi_cs_n   (spi_cs_n)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] onehot(input logic [1:0] g);
    logic [3:0] r;
    r = 4'b0000;
    r[g] = 1'b1;
    return r;
  endfunction

  task automatic wait_ready();
    int k;
    @(negedge clk);
    k = 0;
    while (req_ready == 4'b0000 && k < 8) begin
      cyc();
      @(negedge clk);
      k++;
    end
  endtask

  task automatic do_xfer(input vec_t v);
    logic [3:0] oh;
    logic [3:0] cs_exp;
    oh     = onehot(v.exp_g);
    cs_exp = ~oh;
    cyc();
    req_valid = v.valid;
    req_data  = v.data;
    wait_ready();
    check("grant_ready", req_ready, oh);
    cyc();
    m_busy = 1'b1;
    m_cs_n = 1'b0;
    @(negedge clk);
    check("ready_pulse", req_ready, 4'b0000);
    check("m_start_launch", m_start, 1'b1);
    check("m_data_in", m_data_in, v.exp_tx);
    check("grant_id", grant_id, v.exp_g);
    check("cs_launch", spi_cs_n, cs_exp);
    check("rsp_data_hold", rsp_data, prev_rx);
    cyc();
    m_done     = 1'b1;
    m_data_out = v.rx;
    @(negedge clk);
    check("m_start_wait", m_start, 1'b0);
    check("cs_wait", spi_cs_n, cs_exp);
    check("rsp_valid_wait", rsp_valid, 4'b0000);
    cyc();
    m_done = 1'b0;
    m_busy = 1'b0;
    m_cs_n = 1'b1;
    @(negedge clk);
    check("rsp_valid", rsp_valid, oh);
    check("rsp_data", rsp_data, v.rx);
    check("rsp_err", rsp_err, 1'b0);
    check("cs_resp", spi_cs_n, 4'b1111);
    prev_rx = v.rx;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 4'b0000);
    check({tag, "_rsp_valid"}, rsp_valid, 4'b0000);
    check({tag, "_rsp_data"}, rsp_data, 8'h00);
    check({tag, "_rsp_err"}, rsp_err, 1'b0);
    check({tag, "_grant_id"}, grant_id, 2'd0);
    check({tag, "_m_start"}, m_start, 1'b0);
    check({tag, "_m_data_in"}, m_data_in, 8'h00);
    check({tag, "_spi_cs_n"}, spi_cs_n, 4'b1111);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0]  = '{4'b1111, 32'hD4C3B2A1, 8'h10, 2'd0, 8'hA1};
    vecs[1]  = '{4'b1111, 32'hD4C3B2A1, 8'h11, 2'd1, 8'hB2};
    vecs[2]  = '{4'b1111, 32'hD4C3B2A1, 8'h12, 2'd2, 8'hC3};
    vecs[3]  = '{4'b1111, 32'hD4C3B2A1, 8'h13, 2'd3, 8'hD4};
    vecs[4]  = '{4'b1111, 32'hD4C3B2A1, 8'h14, 2'd0, 8'hA1};
    vecs[5]  = '{4'b0001, 32'h443322AA, 8'h66, 2'd0, 8'hAA};
    vecs[6]  = '{4'b0100, 32'h443322AA, 8'h5C, 2'd2, 8'h33};
    vecs[7]  = '{4'b0011, 32'h443322AA, 8'h81, 2'd0, 8'hAA};
    vecs[8]  = '{4'b0011, 32'h443322AA, 8'h82, 2'd1, 8'h22};
    vecs[9]  = '{4'b1010, 32'h443322AA, 8'hF0, 2'd3, 8'h44};
    vecs[10] = '{4'b1010, 32'h443322AA, 8'h0F, 2'd1, 8'h22};

    rst_n      = 1'b0;
    req_valid  = 4'b0000;
    req_data   = '0;
    m_data_out = '0;
    m_busy     = 1'b0;
    m_done     = 1'b0;
    m_cs_n     = 1'b1;
    prev_rx    = 8'h00;
    cyc();
    cyc();
    @(negedge clk);
    check_reset_outputs("reset");
    cyc();
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      do_xfer(vecs[i]);
    end

    // Launch timeout: master never raises busy; last grant was 1, so 2 wins.
    cyc();
    req_valid = 4'b0100;
    req_data  = 32'h88776655;
    wait_ready();
    check("to_grant", req_ready, 4'b0100);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      cyc();
      req_valid = 4'b0000;
      @(negedge clk);
      if (!m_start) break;
      if (k == 0) check("to_m_data_in", m_data_in, 8'h77);
      n++;
    end
    check("to_start_cycles", n, 16);
    check("to_rsp_valid", rsp_valid, 4'b0100);
    check("to_rsp_err", rsp_err, 1'b1);
    check("to_rsp_data", rsp_data, 8'h00);
    cyc();
    @(negedge clk);
    check("to_idle_rsp_valid", rsp_valid, 4'b0000);
    check("to_err_hold", rsp_err, 1'b1);

    // Stray m_done while idle must be ignored.
    cyc();
    m_done     = 1'b1;
    m_data_out = 8'h5A;
    @(negedge clk);
    check("stray_rsp_valid", rsp_valid, 4'b0000);
    check("stray_m_start", m_start, 1'b0);
    check("stray_cs", spi_cs_n, 4'b1111);
    cyc();
    m_done = 1'b0;
    @(negedge clk);
    check("stray_rsp_valid2", rsp_valid, 4'b0000);
    check("stray_rsp_data", rsp_data, 8'h00);
    check("stray_rsp_err", rsp_err, 1'b1);

    // Reset during WAIT_DONE; still idle, so requester 3 is granted at once.
    cyc();
    req_valid = 4'b1000;
    req_data  = 32'h99000000;
    @(negedge clk);
    check("abort_grant", req_ready, 4'b1000);
    cyc();
    req_valid = 4'b0000;
    m_busy    = 1'b1;
    m_cs_n    = 1'b0;
    @(negedge clk);
    check("abort_cs_launch", spi_cs_n, 4'b0111);
    cyc();
    @(negedge clk);
    check("abort_in_wait", m_start, 1'b0);
    cyc();
    rst_n = 1'b0;
    cyc();
    @(negedge clk);
    check_reset_outputs("abort");
    cyc();
    rst_n  = 1'b1;
    m_busy = 1'b0;
    m_cs_n = 1'b1;
    @(negedge clk);
    check("abort_no_rsp", rsp_valid, 4'b0000);
    prev_rx = 8'h00;
    do_xfer('{4'b1111, 32'h12345678, 8'hC7, 2'd0, 8'h78});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4: number of requesters (2..8).
REQ-002 The block SHALL have parameter DATA_LENGTH, default 8: SPI word width; it must match the SPI master.
REQ-003 The block SHALL have parameter LAUNCH_TIMEOUT, default 16: maximum number of cycles to wait for m_busy after m_start.
REQ-004 The block SHALL have the following ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester transfer request.
- req_data  in  NUM_REQ*DATA_LENGTH  per-requester TX word; requester i uses slice [i*DATA_LENGTH +: DATA_LENGTH].
- req_ready  out  NUM_REQ  per-requester accept, one-hot or zero.
- rsp_valid  out  NUM_REQ  one-cycle response pulse to the granted requester.
- rsp_data  out  DATA_LENGTH  RX word, shared by all requesters.
- rsp_err  out  1  launch-timeout flag, qualified by rsp_valid.
- grant_id  out  $clog2(NUM_REQ)  index of the current or last granted requester.
- m_start  out  1  start to the SPI master.
- m_data_in  out  DATA_LENGTH  TX word to the SPI master.
- m_data_out  in  DATA_LENGTH  RX word from the SPI master.
- m_busy  in  1  SPI master busy.
- m_done  in  1  SPI master done pulse.
- m_cs_n  in  1  chip select produced by the SPI master.
- spi_cs_n  out  NUM_REQ  per-slave chip selects, active-low.

Function
REQ-005 The FSM SHALL have states IDLE, LAUNCH, WAIT_DONE and RESP; its reset state SHALL be IDLE.
REQ-006 In IDLE, when any req_valid is high, the block SHALL grant round-robin, searching from (last_grant+1) mod NUM_REQ upward with wrap-around.
REQ-007 On a grant, the block SHALL pulse req_ready[g] for exactly one cycle, latch req_data slice g into a TX register, set grant_id=g, and move to LAUNCH.
REQ-008 A requester that drops req_valid before it is granted SHALL NOT be served; no request SHALL be accepted outside IDLE.
REQ-009 In LAUNCH, m_start SHALL be high and m_data_in SHALL equal the TX register; when m_busy=1 is sampled, the FSM SHALL move to WAIT_DONE and deassert m_start in the following cycle.
REQ-010 If m_busy is not seen within LAUNCH_TIMEOUT cycles of entering LAUNCH, the FSM SHALL move to RESP with rsp_err=1 and rsp_data=0.
REQ-011 In WAIT_DONE, on m_done=1 the block SHALL capture m_data_out into rsp_data and move to RESP; there SHALL be no timeout in WAIT_DONE.
REQ-012 In RESP, rsp_valid[g] SHALL be high for exactly one cycle; last_grant SHALL be set to g and the FSM SHALL return to IDLE.
REQ-013 rsp_data and rsp_err SHALL hold their values until the next RESP.
REQ-014 The earliest new grant SHALL occur in the cycle after RESP (IDLE dwell is 1 cycle); back-to-back service SHALL therefore be possible.
REQ-015 Chip-select routing:
- In LAUNCH, WAIT_DONE and RESP: spi_cs_n[g] = m_cs_n.
- All other spi_cs_n bits SHALL be 1.
- In IDLE: all spi_cs_n bits SHALL be 1.
REQ-016 m_start SHALL never be high outside LAUNCH.
REQ-017 m_done seen outside WAIT_DONE SHALL be ignored.
REQ-018 The block SHALL issue at most one outstanding transfer.

Reset
REQ-019 On rst_n=0 sampled at a clk edge, the block SHALL drive: state=IDLE, m_start=0, m_data_in=0, req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, grant_id=0, spi_cs_n=all 1s, timeout counter=0.
REQ-020 On reset, last_grant SHALL be set to NUM_REQ-1, so that requester 0 has first priority.
REQ-021 Reset mid-transfer SHALL abort with no rsp_valid issued; the block does not reset the SPI master.

Structure
REQ-022 Package spi_pkg SHALL hold the FSM state enum (arb_state_t) and the default DATA_LENGTH/NUM_REQ/LAUNCH_TIMEOUT constants.
REQ-023 The round-robin pointer search SHALL be a sub-module, spi_rr_arb (inputs: req vector and last_grant; outputs: found and index), which is purely combinational.
REQ-024 The SPI master SHALL NOT be instantiated inside this block; the integration level connects the m_* ports to the master.

Verification
REQ-025 The bench SHALL cover the following directed scenarios:
- Single request: req_valid=0001, data 0xAA; slave returns 0x66 -> m_data_in=0xAA, spi_cs_n[0] follows m_cs_n, spi_cs_n[3:1]=111, rsp_valid=0001, rsp_data=0x66, rsp_err=0.
- Fairness: all four req_valid held high -> grant order 0,1,2,3,0; each req_ready is a 1-cycle pulse.
- Wrap-around: after a grant to 2, requests 0 and 1 only -> grant 0, then 1.
- Timeout: m_busy tied 0 -> m_start high for 16 cycles, then rsp_valid[g]=1, rsp_err=1, rsp_data=0x00, FSM in IDLE.
- Reset mid-transfer: rst_n=0 during WAIT_DONE -> next cycle all outputs at reset values, no rsp_valid; the next request goes to requester 0.
- Stray m_done: m_done pulsed in IDLE -> no rsp_valid and no state change.
